muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative RV32M multiply/divide unit for the Execute stage. It supports all eight M-extension ops in width-generic form, with a start/busy/done handshake, a downstream hold, and a kill for pipeline flushes. It carries the destination register tag so hazard logic can match results. Execute selects its result over the ALU result when done is high.

Parameters:
DATA_WIDTH, 32, operand/result width (even, >=8)
RF_WIDTH, 5, destination register tag width
BITS_PER_CYCLE, 1, bits retired per iteration (1, 2 or 4; must divide DATA_WIDTH)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request a new operation
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  DATA_WIDTH  rs1 operand (forwarded value)
b  in  DATA_WIDTH  rs2 operand (forwarded value)
rdIn  in  RF_WIDTH  destination tag
kill  in  1  abort the current operation (flush)
hold  in  1  downstream stall; freezes the DONE result
busy  out  1  operation in flight; Execute stalls upstream
done  out  1  result valid
result  out  DATA_WIDTH  op result
rdOut  out  RF_WIDTH  tag latched at accept

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n). Reset on rst_n=0 at the edge.
- Reset values: state=IDLE; busy=0, done=0, result=0, rdOut=0; internal accumulators zero. Reset mid-operation discards the op.
- N = DATA_WIDTH/BITS_PER_CYCLE.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, iteration counter 0..N-1.
  - FIN: busy=1, sign fix-up and high/low select.
  - DONE: busy=0, done=1.
- Accept: start sampled high in IDLE, or in DONE with hold=0. On accept, latch op, a, b and rdIn. Operands are not re-read afterwards.
- Normal latency: accept at edge k. CALC occupies cycles k+1..k+N, FIN is cycle k+N+1, done=1 from cycle k+N+2.
- Multiply:
  - Operands are sign/zero-extended per op: MULH signed×signed, MULHSU signed×unsigned, MULHU and MUL unsigned-equivalent.
  - Shift-add on magnitudes, BITS_PER_CYCLE multiplier bits per cycle, into a 2·DATA_WIDTH product.
  - FIN negates the product if the sign flag is set, then selects the low half (MUL) or high half (others).
- Divide:
  - Restoring divide on magnitudes, BITS_PER_CYCLE steps chained per cycle.
  - FIN applies the quotient sign (signs of a and b differ) and the remainder sign (sign of a).
- Special cases are detected at accept, skip CALC and FIN, and give done=1 at cycle k+1:
  - Divisor 0: DIV/DIVU = all ones; REM/REMU = a.
  - Signed overflow (a = most-negative, b = -1, DIV/REM): DIV = a, REM = 0.
- DONE: result and rdOut stay stable while hold=1. When hold=0 and there is no new start, go to IDLE next cycle. When hold=0 and start=1, back-to-back accept: done drops next cycle.
- kill: highest priority after reset. From any state, go to IDLE next cycle with done=0 and busy=0. kill and start in the same cycle means start is ignored.
- start while busy=1 is ignored; the requester must hold start until accepted.
- result holds its last value in IDLE. It is only meaningful when done=1.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, BITS_PER_CYCLE=1 -> result 0xFFFFFFEB; busy cycles 1..33, done at cycle 34; rdOut equals rdIn.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each done at cycle 1 after accept.
- hold=1 for 5 cycles in DONE -> result and done stable. Release with start=1 -> new op accepted the same edge; second result correct. Repeat with BITS_PER_CYCLE=4 -> done at cycle 10.
- kill at CALC cycle 10 -> IDLE next cycle, done never asserts. kill+start in the same cycle -> no accept. rst_n=0 mid-CALC -> all outputs 0 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide on magnitudes,
// sign fix-up in a final cycle, start/busy/done handshake with hold and kill.
module muldiv_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int RF_WIDTH       = 5,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [RF_WIDTH-1:0]   rdIn,
    input  logic                  kill,
    input  logic                  hold,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [RF_WIDTH-1:0]   rdOut
);
    localparam int W  = DATA_WIDTH;
    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    // IDLE: waiting | CALC: iterating | FIN: sign fix-up, half select | DONE: result valid
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [2*W-1:0]  r_acc;     // product, or remainder in the low half
    logic [2*W-1:0]  r_mcand;   // shifted multiplicand, or divisor in the low half
    logic [W-1:0]    r_mplier;  // multiplier, or dividend shifting into quotient
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_result;
    logic [RF_WIDTH-1:0] r_rd;

    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [W-1:0]    w_mag_a, w_mag_b;
    logic            w_div0, w_ovf, w_special, w_accept;
    logic [W-1:0]    w_special_res;

    assign w_a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign w_b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign w_a_neg    = w_a_signed & a[W-1];
    assign w_b_neg    = w_b_signed & b[W-1];
    assign w_mag_a    = w_a_neg ? -a : a;
    assign w_mag_b    = w_b_neg ? -b : b;
    assign w_div0     = op[2] && (b == '0);
    assign w_ovf      = op[2] && !op[0] && (a == MIN_NEG) && (b == '1);
    assign w_special  = w_div0 || w_ovf;
    assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    assign w_accept   = start && !kill && ((r_state == S_IDLE) || ((r_state == S_DONE) && !hold));

    logic [2*W-1:0] w_acc_nx, w_mcand_nx;
    logic [W-1:0]   w_mplier_nx;
    logic [W:0]     w_trial;
    logic [W-1:0]   w_diff;

    always_comb begin
        w_acc_nx    = r_acc;
        w_mcand_nx  = r_mcand;
        w_mplier_nx = r_mplier;
        w_trial     = '0;
        w_diff      = '0;
        if (!r_op[2]) begin
            for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                if (w_mplier_nx[0]) w_acc_nx = w_acc_nx + w_mcand_nx;
                w_mcand_nx  = w_mcand_nx << 1;
                w_mplier_nx = w_mplier_nx >> 1;
            end
        end else begin
            for (int j = 0; j < BITS_PER_CYCLE; j++) begin
                w_trial = {w_acc_nx[W-1:0], w_mplier_nx[W-1]};
                // remainder stays below the divisor, so the difference fits in W bits
                w_diff  = w_trial[W-1:0] - w_mcand_nx[W-1:0];
                if (w_trial >= {1'b0, w_mcand_nx[W-1:0]}) begin
                    w_acc_nx[W-1:0] = w_diff;
                    w_mplier_nx     = {w_mplier_nx[W-2:0], 1'b1};
                end else begin
                    w_acc_nx[W-1:0] = w_trial[W-1:0];
                    w_mplier_nx     = {w_mplier_nx[W-2:0], 1'b0};
                end
            end
        end
    end

    logic [2*W-1:0] w_prod;
    logic [W-1:0]   w_quo, w_rem, w_fin;

    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_quo  = r_neg_q ? -r_mplier : r_mplier;
        w_rem  = r_neg_r ? -r_acc[W-1:0] : r_acc[W-1:0];
        if (r_op[2])              w_fin = r_op[1] ? w_rem : w_quo;
        else if (r_op == OP_MUL)  w_fin = w_prod[W-1:0];
        else                      w_fin = w_prod[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (kill) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_op     <= op;
                        r_rd     <= rdIn;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_acc    <= '0;
                        r_mcand  <= {{W{1'b0}}, op[2] ? w_mag_b : w_mag_a};
                        r_mplier <= op[2] ? w_mag_a : w_mag_b;
                        r_cnt    <= CNT_LAST;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end else if ((r_state == S_DONE) && !hold) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_nx;
                    r_mcand  <= w_mcand_nx;
                    r_mplier <= w_mplier_nx;
                    if (r_cnt == '0) r_state <= S_FIN;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                S_FIN: begin
                    r_result <= w_fin;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign rdOut  = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random ops against an arithmetic reference model,
// with handshake latency, hold, kill and reset checks on 1- and 4-bit-per-cycle instances.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start1, start4, kill_i, hold_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  rd_i;
    logic        busy1, done1, busy4, done4;
    logic [31:0] res1, res4;
    logic [4:0]  rdo1, rdo4;

    muldiv_unit #(.DATA_WIDTH(32), .RF_WIDTH(5), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op_i), .a(a_i), .b(b_i),
        .rdIn(rd_i), .kill(kill_i), .hold(hold_i), .busy(busy1), .done(done1),
        .result(res1), .rdOut(rdo1));

    muldiv_unit #(.DATA_WIDTH(32), .RF_WIDTH(5), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op_i), .a(a_i), .b(b_i),
        .rdIn(rd_i), .kill(kill_i), .hold(hold_i), .busy(busy4), .done(done4),
        .result(res4), .rdOut(rdo4));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        logic [63:0] ux = {32'b0, x};
        logic [63:0] uy = {32'b0, y};
        logic [63:0] p;
        logic ovf = (x == MIN_NEG) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * longint'(uy)); return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'(sx / sy));
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: return (y == 0) ? x : (ovf ? 32'd0 : 32'(sx % sy));
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Drives one op at a falling edge, then follows it to done; returns at the done falling edge.
    task automatic do_op(input bit use4, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] rd, input string tag);
        int n_it = use4 ? 8 : 32;
        bit special = (o[2] && y == 0) || (o[2] && !o[0] && x == MIN_NEG && y == 32'hFFFF_FFFF);
        logic [31:0] exp = ref_md(o, x, y);
        int busy_n = 0;
        int done_c = 0;
        op_i = o; a_i = x; b_i = y; rd_i = rd; hold_i = 1'b0;
        if (use4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start4 = 1'b0;
        for (int c = 1; c <= 60 && done_c == 0; c++) begin
            if (use4 ? busy4 : busy1) busy_n++;
            if (use4 ? done4 : done1) done_c = c;
            else @(negedge clk);
        end
        check_eq({tag, " done_cycle"}, 64'(done_c), special ? 64'd1 : 64'(n_it + 2));
        check_eq({tag, " busy_cycles"}, 64'(busy_n), special ? 64'd0 : 64'(n_it + 1));
        if (done_c != 0) begin
            check_eq({tag, " result"}, 64'(use4 ? res4 : res1), 64'(exp));
            check_eq({tag, " rdOut"}, 64'(use4 ? rdo4 : rdo1), 64'(rd));
        end
    endtask

    initial begin
        bit seen;
        logic [31:0] hexp;
        rst_n = 1'b0; start1 = 0; start4 = 0; kill_i = 0; hold_i = 0;
        op_i = 0; a_i = 0; b_i = 0; rd_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst busy1", 64'(busy1), 0);
        check_eq("rst done1", 64'(done1), 0);
        check_eq("rst result1", 64'(res1), 0);
        check_eq("rst rdOut1", 64'(rdo1), 0);
        check_eq("rst busy4", 64'(busy4), 0);
        check_eq("rst done4", 64'(done4), 0);
        rst_n = 1'b1;

        do_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, "mul");
        do_op(0, 3'd1, MIN_NEG, MIN_NEG, 5'd4, "mulh");
        do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, "mulhu");
        do_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, "mulhsu");
        do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, "div");
        do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, "rem");
        do_op(0, 3'd5, 32'd100, 32'd7, 5'd9, "divu");
        do_op(0, 3'd7, 32'd100, 32'd7, 5'd10, "remu");
        do_op(0, 3'd5, 32'd5, 32'd0, 5'd11, "divu_by0");
        do_op(0, 3'd7, 32'd5, 32'd0, 5'd12, "remu_by0");
        do_op(0, 3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd13, "div_ovf");
        do_op(0, 3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd14, "rem_ovf");

        // Hold the result, then release with a back-to-back start
        do_op(0, 3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd15, "hold_op");
        hexp = ref_md(3'd1, 32'h1234_5678, 32'hFEDC_BA98);
        hold_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold done", 64'(done1), 1);
            check_eq("hold result", 64'(res1), 64'(hexp));
            check_eq("hold rdOut", 64'(rdo1), 15);
        end
        do_op(0, 3'd6, 32'd1000, 32'hFFFF_FFF3, 5'd16, "b2b_rem");

        do_op(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17, "mul_bpc4");
        do_op(1, 3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd18, "mulh_bpc4");
        do_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd19, "div_bpc4");

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro = 3'($urandom_range(0, 7));
            logic [31:0] ra = $urandom;
            logic [31:0] rb = $urandom;
            int mode = $urandom_range(0, 9);
            if (mode == 0) rb = 0;
            else if (mode == 1) begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
            else if (mode == 2) rb = $urandom_range(1, 15);
            else if (mode == 3) ra = $urandom_range(0, 255);
            do_op($urandom_range(0, 3) == 0, ro, ra, rb, 5'($urandom_range(0, 31)), "rand");
        end

        // Kill during the tenth CALC cycle
        @(negedge clk);
        op_i = 3'd5; a_i = 32'd12345; b_i = 32'd77; rd_i = 5'd21; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check_eq("kill busy", 64'(busy1), 0);
        check_eq("kill done", 64'(done1), 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 || busy1) seen = 1;
        end
        check_eq("kill no_done", 64'(seen), 0);

        // kill and start together must not accept
        op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; start1 = 1'b1; kill_i = 1'b1;
        @(negedge clk);
        start1 = 1'b0; kill_i = 1'b0;
        check_eq("killstart busy", 64'(busy1), 0);
        check_eq("killstart done", 64'(done1), 0);
        repeat (3) @(negedge clk);
        check_eq("killstart idle", 64'(busy1 | done1), 0);

        // Reset in the middle of CALC
        do_op(0, 3'd0, 32'd3, 32'd5, 5'd9, "pre_rst");
        op_i = 3'd3; a_i = 32'hCAFE_0001; b_i = 32'h1234_0002; rd_i = 5'd22; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrst busy", 64'(busy1), 0);
        check_eq("midrst done", 64'(done1), 0);
        check_eq("midrst result", 64'(res1), 0);
        check_eq("midrst rdOut", 64'(rdo1), 0);
        rst_n = 1'b1;
        do_op(0, 3'd7, 32'd100, 32'd7, 5'd2, "post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
